// File: rtl/cla_arbiter.sv
// Round-robin arbiter sharing one carry-lookahead adder between NUM_REQ requesters.
// Latency: request accepted in cycle N -> tagged sum in the response buffer in cycle N+1.
// Backpressure: a full response buffer with i_rsp_ready low drops every o_req_ready bit and holds result/id.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req_valid/o_req_ready per-requester handshake (at most one ready bit set, combinational from valid)
//   i_req_add1/i_req_add2   packed operands, requester k in slice [k*WIDTH +: WIDTH]
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_result/o_rsp_id   WIDTH+1-bit sum (carry-out in MSB) and the winning requester index
// Optional: define CLA_ARB_STATS_EN to add o_stall_cnt, a saturating 16-bit count of
//           cycles where a response is held because the consumer is not ready.

// Unsigned adder with no carry-in. Every carry is a flat sum-of-products of the
// generate/propagate terms below it, so no carry depends on a previous carry.
module carry_lookahead_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] add1,
    input  logic [WIDTH-1:0] add2,
    output logic [WIDTH:0]   result
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = add1 & add2;
    // XOR propagate doubles as the half-sum; it is never set together with gen,
    // so it is equally valid in the carry equations.
    assign prop = add1 ^ add2;

    // carry[i] = OR over j<i of ( gen[j] AND prop[j+1] AND ... AND prop[i-1] )
    always_comb begin : lookahead
        logic run;
        logic acc;
        carry = '0;
        run   = 1'b0;
        acc   = 1'b0;
        for (int i = 1; i <= WIDTH; i++) begin
            acc = 1'b0;
            for (int j = 0; j < i; j++) begin
                run = gen[j];
                for (int k = j + 1; k < i; k++) begin
                    run = run & prop[k];
                end
                acc = acc | run;
            end
            carry[i] = acc;
        end
    end

    assign result = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};

endmodule

module cla_arbiter #(
    parameter int  WIDTH   = 8,
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_add1,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_add2,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [WIDTH:0]           o_rsp_result,
    output logic [ID_W-1:0]          o_rsp_id
`ifdef CLA_ARB_STATS_EN
    ,
    output logic [15:0]              o_stall_cnt
`endif
);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  ptr_next;
    logic             any_valid;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] sel_add1;
    logic [WIDTH-1:0] sel_add2;
    logic [WIDTH:0]   sum;

    // Scan from the highest offset down so the lowest offset from ptr that
    // is valid overwrites the others and ends up as the winner.
    always_comb begin : rr_pick
        int idx;
        idx       = 0;
        winner    = ptr;
        any_valid = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (i_req_valid[idx]) begin
                winner    = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

    // The buffer can take a new result when empty or being drained this cycle.
    assign can_accept = !o_rsp_valid || i_rsp_ready;
    assign accept     = any_valid && can_accept;

    always_comb begin : ready_gen
        o_req_ready = '0;
        if (accept) begin
            o_req_ready[winner] = 1'b1;
        end
    end

    // Pointer wraps explicitly so non-power-of-two NUM_REQ never points past the last requester.
    assign ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    assign sel_add1 = i_req_add1[winner*WIDTH +: WIDTH];
    assign sel_add2 = i_req_add2[winner*WIDTH +: WIDTH];

    carry_lookahead_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .add1   (sel_add1),
        .add2   (sel_add2),
        .result (sum)
    );

    // Response buffer and round-robin pointer. An accept always (re)loads the
    // buffer, which covers the simultaneous drain+accept case at full rate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_valid  <= 1'b0;
            o_rsp_result <= '0;
            o_rsp_id     <= '0;
            ptr          <= '0;
        end else if (accept) begin
            o_rsp_valid  <= 1'b1;
            o_rsp_result <= sum;
            o_rsp_id     <= winner;
            ptr          <= ptr_next;
        end else if (i_rsp_ready) begin
            o_rsp_valid  <= 1'b0;
        end
    end

`ifdef CLA_ARB_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
        end else if (o_rsp_valid && !i_rsp_ready && (o_stall_cnt != 16'hFFFF)) begin
            o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cla_arbiter.sv
// Bench for cla_arbiter (WIDTH=8, NUM_REQ=4): a reference model predicts ready,
// pushes expected {id,sum} on each accept and pops/compares on each drain.
// Runs in either build; the stall counter is checked only when it exists.
module tb_cla_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_vld;
    logic [NUM_REQ-1:0]       req_rdy;
    logic [NUM_REQ*WIDTH-1:0] add1;
    logic [NUM_REQ*WIDTH-1:0] add2;
    logic                     rsp_vld;
    logic                     rsp_rdy;
    logic [WIDTH:0]           rsp_dat;
    logic [1:0]               rsp_id;
`ifdef CLA_ARB_STATS_EN
    logic [15:0]              stall_cnt;
`endif

    cla_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_vld),
        .o_req_ready  (req_rdy),
        .i_req_add1   (add1),
        .i_req_add2   (add2),
        .o_rsp_valid  (rsp_vld),
        .i_rsp_ready  (rsp_rdy),
        .o_rsp_result (rsp_dat),
        .o_rsp_id     (rsp_id)
`ifdef CLA_ARB_STATS_EN
        ,
        .o_stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [10:0] sb[$];      // {id[1:0], sum[8:0]}
    int          m_ptr;
    logic        m_vld;
    int          m_stall;
    logic        sticky;     // requesters re-present the same request after accept

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int m_winner(input logic [NUM_REQ-1:0] v, input int p);
        for (int off = 0; off < NUM_REQ; off++) begin
            if (v[(p + off) % NUM_REQ]) return (p + off) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_ptr   = 0;
        m_vld   = 1'b0;
        m_stall = 0;
    endtask

    task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b);
        add1[k*WIDTH +: WIDTH] = a;
        add2[k*WIDTH +: WIDTH] = b;
        req_vld[k] = 1'b1;
    endtask

    // One clock: checks at the negedge, advances the model, returns at posedge+1.
    task automatic run_cycle();
        int                 w;
        int                 acc_w;
        logic               can;
        logic               drain;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [8:0]         exp_sum;
        logic [10:0]        front;
        @(negedge clk);
        w       = m_winner(req_vld, m_ptr);
        can     = !m_vld || rsp_rdy;
        exp_rdy = '0;
        acc_w   = -1;
        if (w >= 0 && can) begin
            exp_rdy[w] = 1'b1;
            acc_w      = w;
        end
        check_eq("req_ready", 32'(req_rdy), 32'(exp_rdy));
        check_eq("rsp_valid", 32'(rsp_vld), 32'(m_vld));
        if (m_vld) begin
            check_eq("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
                front = sb[0];
                check_eq("rsp_result", 32'(rsp_dat), 32'(front[8:0]));
                check_eq("rsp_id", 32'(rsp_id), 32'(front[10:9]));
            end
        end
        drain = m_vld && rsp_rdy;
        if (drain && sb.size() > 0) void'(sb.pop_front());
        if (m_vld && !rsp_rdy && m_stall < 16'hFFFF) m_stall++;
        if (acc_w >= 0) begin
            exp_sum = {1'b0, add1[acc_w*WIDTH +: WIDTH]} + {1'b0, add2[acc_w*WIDTH +: WIDTH]};
            sb.push_back({2'(acc_w), exp_sum});
            m_ptr = (acc_w + 1) % NUM_REQ;
            m_vld = 1'b1;
        end else if (drain) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
        if (acc_w >= 0 && !sticky) req_vld[acc_w] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        req_vld = '0;
        add1    = '0;
        add2    = '0;
        rsp_rdy = 1'b0;
        sticky  = 1'b0;
        model_reset();

        // Reset values
        #2;
        check_eq("rst_rsp_valid", 32'(rsp_vld), 0);
        check_eq("rst_rsp_result", 32'(rsp_dat), 0);
        check_eq("rst_rsp_id", 32'(rsp_id), 0);
        check_eq("rst_req_ready", 32'(req_rdy), 0);
`ifdef CLA_ARB_STATS_EN
        check_eq("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
        #6;
        rst_n = 1'b1;
        run_cycle();
        run_cycle();

        // Single request: req1 0xFF + 0x01
        rsp_rdy = 1'b1;
        set_req(1, 8'hFF, 8'h01);
        run_cycle();
        check_eq("single_result", 32'(rsp_dat), 32'h100);
        check_eq("single_id", 32'(rsp_id), 1);
        run_cycle();

        // All four held valid from ptr=0: order 0,1,2,3,0
        do_reset();
        sticky = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) set_req(k, 8'(k), 8'(16 * k));
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            check_eq("rr_order", 32'(rsp_id), 32'(c % NUM_REQ));
        end
        sticky  = 1'b0;
        req_vld = '0;
        run_cycle();

        // Backpressure: buffered result held 3 cycles, then drain+accept together
        do_reset();
        rsp_rdy = 1'b0;
        set_req(0, 8'h12, 8'h34);
        run_cycle();
        set_req(2, 8'h56, 8'h78);
        for (int c = 0; c < 3; c++) run_cycle();
`ifdef CLA_ARB_STATS_EN
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check_eq("stall_cnt_3", 32'(stall_cnt), 3);
`endif
        rsp_rdy = 1'b1;
        run_cycle();
        check_eq("bp_next_id", 32'(rsp_id), 2);
        run_cycle();

        // Reset mid-operation: buffered result discarded asynchronously
        rsp_rdy = 1'b0;
        set_req(3, 8'hAA, 8'h55);
        run_cycle();
        check_eq("pre_rst_valid", 32'(rsp_vld), 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(rsp_vld), 0);
        check_eq("async_rst_result", 32'(rsp_dat), 0);
        model_reset();
        req_vld = '0;
        set_req(0, 8'h01, 8'h02);
        set_req(2, 8'h03, 8'h04);
        #1;
        rst_n   = 1'b1;
        rsp_rdy = 1'b1;
        run_cycle();
        check_eq("post_rst_winner", 32'(rsp_id), 0);
        run_cycle();
        run_cycle();

        // Corner sums on different requesters
        set_req(1, 8'h00, 8'h00);
        run_cycle();
        check_eq("corner_zero", 32'(rsp_dat), 32'h000);
        set_req(3, 8'hFF, 8'hFF);
        run_cycle();
        check_eq("corner_max", 32'(rsp_dat), 32'h1FE);
        set_req(0, 8'h80, 8'h80);
        run_cycle();
        check_eq("corner_carry", 32'(rsp_dat), 32'h100);
        run_cycle();
        run_cycle();
        check_eq("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
